// File: rtl/mult_result_accumulator.sv
// mult_result_accumulator
//   Sums every BATCH_LEN valid multiplier results into one ACC_WIDTH-bit total,
//   buffers totals in a show-ahead FIFO and offers them on a valid/ready port.
//   The input side cannot be stalled, so a completed total that meets a full
//   FIFO (with no pop on the same edge) is dropped and counted.
//   Optional build macro: MULT_ACC_SATURATE_EN clamps the running sum at all
//   ones instead of wrapping modulo 2^ACC_WIDTH.
//
// Output handshake: acc_o/acc_valid_o are a valid/ready pair. A transfer
// happens on a rising edge where acc_valid_o && acc_ready_i. While
// acc_valid_o=1 and acc_ready_i=0 both outputs hold. acc_valid_o never
// depends combinationally on acc_ready_i. When empty, acc_o reads 0.
module mult_result_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int BATCH_LEN  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  clear_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  acc_valid_o,
  input  logic                  acc_ready_i,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic [7:0]            drop_count_o
);

  // Beat counter is kept at least one bit wide so BATCH_LEN=1 still elaborates.
  localparam int CNT_W = (BATCH_LEN > 1) ? $clog2(BATCH_LEN) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BATCH_LEN - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  // Accumulator state
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // FIFO state
  logic [ACC_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ACC_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;

  // Drop status
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  // Per-cycle decode
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 beat;
  logic                 push_req;
  logic                 pop;
  logic                 fifo_full;
  logic                 push_ok;
  logic                 drop;

  // Running-sum adder: zero-extended data, wrap or clamp depending on build.
`ifdef MULT_ACC_SATURATE_EN
  logic [ACC_WIDTH:0] add_wide;
  always_comb begin
    add_wide = {1'b0, sum_q} + {1'b0, ACC_WIDTH'(data_i)};
    add_sum  = add_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : add_wide[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    add_sum = sum_q + ACC_WIDTH'(data_i);
  end
`endif

  // Beat classification, FIFO push/pop/drop decisions.
  always_comb begin
    // clear_i discards any beat presented in the same cycle.
    beat      = data_valid_i && !clear_i;
    push_req  = beat && (cnt_q == LAST_BEAT);
    pop       = (occ_q != '0) && acc_ready_i;
    fifo_full = (occ_q == OCC_FULL);
    // A full FIFO still accepts a push when its head leaves on the same edge.
    push_ok   = push_req && (!fifo_full || pop);
    drop      = push_req && fifo_full && !pop;
  end

  // Accumulator next state: clear dominates, then batch end, then add.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (push_req) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (beat) begin
      sum_d = add_sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // FIFO next state: write completed total at tail, advance head on pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = add_sum;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Drop status next state: sticky flag and saturating counter, cleared by clear_i.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Outputs: registered head entry, forced to zero when empty.
  always_comb begin
    acc_valid_o  = (occ_q != '0);
    acc_o        = acc_valid_o ? mem_q[rd_ptr_q] : '0;
    busy_o       = (cnt_q != '0);
    overflow_o   = overflow_q;
    drop_count_o = drop_cnt_q;
  end

endmodule

// File: tb/tb_mult_result_accumulator.sv
// Directed bench for mult_result_accumulator: default instance plus a
// 9-bit-accumulator instance for the wrap/saturate case.
module tb_mult_result_accumulator;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic        dvalid;
  logic        clear;
  logic        ready;
  logic [15:0] acc;
  logic        acc_valid;
  logic        busy;
  logic        ovf;
  logic [7:0]  drops;

  logic [7:0]  data9;
  logic        dvalid9;
  logic        ready9;
  logic [8:0]  acc9;
  logic        acc_valid9;
  logic        busy9;
  logic        ovf9;
  logic [7:0]  drops9;

  int total;
  int bad;

  mult_result_accumulator u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .data_valid_i (dvalid),
    .clear_i      (clear),
    .acc_o        (acc),
    .acc_valid_o  (acc_valid),
    .acc_ready_i  (ready),
    .busy_o       (busy),
    .overflow_o   (ovf),
    .drop_count_o (drops)
  );

  mult_result_accumulator #(.ACC_WIDTH(9)) u_dut9 (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data9),
    .data_valid_i (dvalid9),
    .clear_i      (1'b0),
    .acc_o        (acc9),
    .acc_valid_o  (acc_valid9),
    .acc_ready_i  (ready9),
    .busy_o       (busy9),
    .overflow_o   (ovf9),
    .drop_count_o (drops9)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; observation happens 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    data   = d;
    dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    data   = '0;
  endtask

  task automatic idle();
    dvalid = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] e_acc, input logic e_valid);
    check({tag, "_valid"}, 32'(acc_valid), 32'(e_valid));
    check({tag, "_acc"},   32'(acc),       32'(e_acc));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    data    = '0;
    dvalid  = 1'b0;
    clear   = 1'b0;
    ready   = 1'b0;
    data9   = '0;
    dvalid9 = 1'b0;
    ready9  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_out("rst", 16'd0, 1'b0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_drops", 32'(drops), 32'd0);

    // Basic batch
    ready = 1'b1;
    beat(8'd10); check("b1_busy", 32'(busy), 32'd1); check_out("b1", 16'd0, 1'b0);
    beat(8'd20); check("b2_busy", 32'(busy), 32'd1);
    beat(8'd30); check("b3_busy", 32'(busy), 32'd1); check_out("b3", 16'd0, 1'b0);
    beat(8'd40); check("b4_busy", 32'(busy), 32'd0); check_out("b4", 16'd100, 1'b1);
    idle();      check_out("b_after", 16'd0, 1'b0);

    // Gaps and order
    ready = 1'b0;
    beat(8'd1); idle(); beat(8'd2); idle(); idle(); beat(8'd3);
    check_out("gap_pre", 16'd0, 1'b0);
    beat(8'd4);
    check_out("gap_t1", 16'd10, 1'b1);
    beat(8'd5); beat(8'd6); beat(8'd7); beat(8'd8);
    check_out("gap_hold", 16'd10, 1'b1);
    idle();
    check_out("gap_hold2", 16'd10, 1'b1);
    ready = 1'b1;
    idle(); check_out("gap_t2", 16'd26, 1'b1);
    idle(); check_out("gap_empty", 16'd0, 1'b0);

    // Overflow: three batches of 1,1,1,1 into a 2-deep FIFO
    ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) beat(8'd1);
    end
    check_out("ovf_head", 16'd4, 1'b1);
    check("ovf_flag",  32'(ovf),   32'd1);
    check("ovf_drops", 32'(drops), 32'd1);
    // Full FIFO, pop and completing push on the same edge
    beat(8'd1); beat(8'd1); beat(8'd1);
    ready = 1'b1;
    beat(8'd2);
    ready = 1'b0;
    check_out("fullpp_head", 16'd4, 1'b1);
    check("fullpp_drops", 32'(drops), 32'd1);
    idle();
    check_out("fullpp_hold", 16'd4, 1'b1);
    ready = 1'b1;
    idle(); check_out("fullpp_t2", 16'd5, 1'b1);
    idle(); check_out("fullpp_empty", 16'd0, 1'b0);

    // Drop counter saturation: fill, then 258 more dropped batches
    ready = 1'b0;
    for (int b = 0; b < 260; b++) begin
      for (int k = 0; k < 4; k++) beat(8'd3);
    end
    check("sat_drops", 32'(drops), 32'd255);
    check("sat_flag",  32'(ovf),   32'd1);
    check_out("sat_head", 16'd12, 1'b1);

    // clear_i: flushes partial sum and drop status, not FIFO contents
    beat(8'd5); beat(8'd5);
    data   = 8'd5;
    dvalid = 1'b1;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
    dvalid = 1'b0;
    check("clr_busy",  32'(busy),  32'd0);
    check("clr_ovf",   32'(ovf),   32'd0);
    check("clr_drops", 32'(drops), 32'd0);
    check_out("clr_fifo_kept", 16'd12, 1'b1);
    ready = 1'b1;
    idle(); idle();
    check_out("clr_drained", 16'd0, 1'b0);
    beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
    check_out("clr_total", 16'd10, 1'b1);
    idle();
    check_out("clr_empty", 16'd0, 1'b0);
    check("clr_ovf2",   32'(ovf),   32'd0);
    check("clr_drops2", 32'(drops), 32'd0);

    // Wrap vs saturate on 9-bit accumulator
    for (int k = 0; k < 4; k++) begin
      data9   = 8'd255;
      dvalid9 = 1'b1;
      tick();
    end
    dvalid9 = 1'b0;
    check("w9_valid", 32'(acc_valid9), 32'd1);
`ifdef MULT_ACC_SATURATE_EN
    check("w9_acc", 32'(acc9), 32'd511);
`else
    check("w9_acc", 32'(acc9), 32'd508);
`endif
    idle();
    check("w9_empty", 32'(acc_valid9), 32'd0);

    // Reset mid-operation
    ready = 1'b0;
    beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
    beat(8'd7); beat(8'd7);
    check_out("mid_buf", 16'd10, 1'b1);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("mid_rst", 16'd0, 1'b0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovf",  32'(ovf),  32'd0);
    ready = 1'b1;
    beat(8'd1); beat(8'd2); beat(8'd3);
    check_out("mid_pre", 16'd0, 1'b0);
    beat(8'd4);
    check_out("mid_total", 16'd10, 1'b1);
    idle();
    check_out("mid_empty", 16'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
